// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state, branch-mode and transfer-size definitions for the data-memory stage
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_RESP      = 2'd2
  } state_e;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_CBZ  = 2'b01;
  localparam logic [1:0] BR_CBNZ = 2'b10;
  localparam logic [1:0] BR_BLT  = 2'b11;

  localparam logic [3:0] XFER_BYTE  = 4'd1;
  localparam logic [3:0] XFER_HALF  = 4'd2;
  localparam logic [3:0] XFER_WORD  = 4'd4;
  localparam logic [3:0] XFER_DWORD = 4'd8;

  // A size is usable only if it is a power-of-two byte count that fits the datapath.
  function automatic logic size_legal(input logic [3:0] sz, input int max_bytes);
    return ((sz == XFER_BYTE) || (sz == XFER_HALF) || (sz == XFER_WORD) || (sz == XFER_DWORD))
           && (int'(sz) <= max_bytes);
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// rtl/dmem_byte_array.sv - byte-addressed big-endian data array, sync write, comb read, sync clear
module dmem_byte_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 128,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [3:0]        wsize,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  input  logic [3:0]        rsize,
  output logic [DATA_W-1:0] rdata
);

  localparam int NB = DATA_W / 8;

  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];

  // Next memory image: low-order data byte i lands at addr + size-1-i (MSB at the base address).
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (i < int'(wsize)) begin
          mem_d[waddr + AW'(int'(wsize) - 1 - i)] = wdata[i*8 +: 8];
        end
      end
    end
  end

  // Memory storage; reset clears every byte and overrides a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: 8'h00};
    end else begin
      mem_q <= mem_d;
    end
  end

  // Sized big-endian read, right-justified and zero-extended.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < int'(rsize)) begin
        rdata[i*8 +: 8] = mem_q[raddr + AW'(int'(rsize) - 1 - i)];
      end
    end
  end

endmodule

// File: rtl/dmem_stage_unit.sv
// rtl/dmem_stage_unit.sv - multi-cycle memory-access stage with branch resolve; DMEM_ALIGN_CHECK_EN enables misalignment errors
module dmem_stage_unit
  import dmem_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 128,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  input  logic [3:0]        xfer_size,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] new_pc_ex,
  input  logic              branch,
  input  logic [1:0]        br_mode,
  input  logic              zero,
  input  logic              negative,
  input  logic              overflow,
  output logic              out_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_to_reg_out,
  output logic              br_taken,
  output logic [DATA_W-1:0] new_pc,
  output logic [DATA_W-1:0] dm_address,
  output logic              err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        size_q, size_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              mem_to_reg_out_q, mem_to_reg_out_d;
  logic              br_taken_q, br_taken_d;
  logic [DATA_W-1:0] new_pc_q, new_pc_d;
  logic [DATA_W-1:0] dm_address_q, dm_address_d;
  logic              err_q, err_d;

  logic              size_ok, range_err, misalign, mem_op, err_c, br_taken_c, mem_we;
  logic [DATA_W:0]   end_addr;
  logic [AW-1:0]     rd_addr;
  logic [3:0]        rd_size;
  logic [DATA_W-1:0] rd_bytes;

  // Checks act on the operation presented in IDLE; non-memory operations ignore size and address.
  assign size_ok   = size_legal(xfer_size, DATA_W / 8);
  assign end_addr  = {1'b0, alu_result} + {{(DATA_W-3){1'b0}}, xfer_size};
  assign range_err = end_addr > (DATA_W+1)'(DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign  = size_ok & ((alu_result[3:0] & (xfer_size - 4'd1)) != 4'd0);
`else
  assign misalign  = 1'b0;
`endif
  assign mem_op    = mem_read | mem_write;
  assign err_c     = (mem_read & mem_write) | (mem_op & (~size_ok | range_err | misalign));

  assign br_taken_c = branch
                    | ((br_mode == BR_CBZ)  & zero)
                    | ((br_mode == BR_CBNZ) & ~zero)
                    | ((br_mode == BR_BLT)  & (negative ^ overflow));

  // In IDLE the array reads the live address (covers RD_LAT = 1); afterwards the latched one.
  assign rd_addr = (state_q == ST_IDLE) ? alu_result[AW-1:0] : dm_address_q[AW-1:0];
  assign rd_size = (state_q == ST_IDLE) ? xfer_size : size_q;
  assign mem_we  = (state_q == ST_IDLE) & in_valid & mem_write & ~err_c;

  dmem_byte_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .we     (mem_we),
    .waddr  (alu_result[AW-1:0]),
    .wsize  (xfer_size),
    .wdata  (write_data),
    .raddr  (rd_addr),
    .rsize  (rd_size),
    .rdata  (rd_bytes)
  );

  // Next-state and result capture: latch on accept, count down loads, pulse once in RESP.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    size_d           = size_q;
    rd_data_d        = rd_data_q;
    mem_to_reg_out_d = mem_to_reg_out_q;
    br_taken_d       = br_taken_q;
    new_pc_d         = new_pc_q;
    dm_address_d     = dm_address_q;
    err_d            = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          size_d           = xfer_size;
          dm_address_d     = alu_result;
          new_pc_d         = new_pc_ex;
          mem_to_reg_out_d = mem_to_reg;
          br_taken_d       = br_taken_c;
          err_d            = err_c;
          rd_data_d        = '0;
          state_d          = ST_RESP;
          if (mem_read && !err_c) begin
            if (RD_LAT == 1) begin
              rd_data_d = rd_bytes;
            end else begin
              cnt_d   = CNT_W'(RD_LAT - 1);
              state_d = ST_LOAD_WAIT;
            end
          end
        end
      end
      ST_LOAD_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) begin
          rd_data_d = rd_bytes;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    out_valid_d = (state_d == ST_RESP);
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      size_q           <= '0;
      out_valid_q      <= 1'b0;
      rd_data_q        <= '0;
      mem_to_reg_out_q <= 1'b0;
      br_taken_q       <= 1'b0;
      new_pc_q         <= '0;
      dm_address_q     <= '0;
      err_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      size_q           <= size_d;
      out_valid_q      <= out_valid_d;
      rd_data_q        <= rd_data_d;
      mem_to_reg_out_q <= mem_to_reg_out_d;
      br_taken_q       <= br_taken_d;
      new_pc_q         <= new_pc_d;
      dm_address_q     <= dm_address_d;
      err_q            <= err_d;
    end
  end

  assign in_ready       = (state_q == ST_IDLE);
  assign out_valid      = out_valid_q;
  assign rd_data        = rd_data_q;
  assign mem_to_reg_out = mem_to_reg_out_q;
  assign br_taken       = br_taken_q;
  assign new_pc         = new_pc_q;
  assign dm_address     = dm_address_q;
  assign err            = err_q;

endmodule

// File: tb/tb_dmem_stage_unit.sv
// tb/tb_dmem_stage_unit.sv - directed and randomized self-checking bench for dmem_stage_unit
module tb_dmem_stage_unit;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 128;
  localparam int RD_LAT = 2;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic              mem_read;
  logic              mem_write;
  logic              mem_to_reg;
  logic [3:0]        xfer_size;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] new_pc_ex;
  logic              branch;
  logic [1:0]        br_mode;
  logic              zero;
  logic              negative;
  logic              overflow;
  logic              out_valid;
  logic [DATA_W-1:0] rd_data;
  logic              mem_to_reg_out;
  logic              br_taken;
  logic [DATA_W-1:0] new_pc;
  logic [DATA_W-1:0] dm_address;
  logic              err;

  int         tests;
  int         fails;
  logic [7:0] ref_mem [DEPTH];
  logic [3:0] size_tab [6] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd8};

  dmem_stage_unit #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_to_reg     (mem_to_reg),
    .xfer_size      (xfer_size),
    .alu_result     (alu_result),
    .write_data     (write_data),
    .new_pc_ex      (new_pc_ex),
    .branch         (branch),
    .br_mode        (br_mode),
    .zero           (zero),
    .negative       (negative),
    .overflow       (overflow),
    .out_valid      (out_valid),
    .rd_data        (rd_data),
    .mem_to_reg_out (mem_to_reg_out),
    .br_taken       (br_taken),
    .new_pc         (new_pc),
    .dm_address     (dm_address),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural memory model: sized big-endian bytes in a plain array.
  task automatic model(input logic rd, input logic wr, input logic [3:0] sz, input logic [63:0] addr,
                       input logic [63:0] wdata, output logic exp_err, output logic [63:0] exp_rd);
    logic       legal, oob, mis;
    logic [64:0] last;
    int         a;
    legal = (sz == 4'd1) || (sz == 4'd2) || (sz == 4'd4) || (sz == 4'd8);
    last  = {1'b0, addr} + 65'(sz);
    oob   = last > 65'(DEPTH);
    mis   = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    mis   = legal && ((addr % 64'(sz)) != 64'd0);
`endif
    exp_err = (rd && wr) || ((rd || wr) && (!legal || oob || mis));
    exp_rd  = 64'd0;
    a       = int'(addr[31:0]);
    if (!exp_err && rd) begin
      for (int k = 0; k < int'(sz); k++) exp_rd = (exp_rd << 8) | 64'(ref_mem[a + k]);
    end
    if (!exp_err && wr) begin
      for (int k = 0; k < int'(sz); k++) ref_mem[a + k] = 8'(wdata >> (8 * (int'(sz) - 1 - k)));
    end
  endtask

  // One full handshake with checks on every registered result, latency and pulse width.
  task automatic exec(input string tag, input logic rd, input logic wr, input logic [3:0] sz,
                      input logic [63:0] addr, input logic [63:0] wdata, input logic br,
                      input logic [1:0] mode, input logic [2:0] znv, input logic [63:0] npc);
    logic        exp_err, exp_br, m2r;
    logic [63:0] exp_rd;
    int          lat, guard;
    m2r = 1'($urandom_range(0, 1));
    model(rd, wr, sz, addr, wdata, exp_err, exp_rd);
    exp_br = br || (mode == 2'd1 && znv[2]) || (mode == 2'd2 && !znv[2])
                || (mode == 2'd3 && (znv[1] != znv[0]));
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_to_reg = m2r; xfer_size = sz;
    alu_result = addr; write_data = wdata; new_pc_ex = npc; branch = br; br_mode = mode;
    zero = znv[2]; negative = znv[1]; overflow = znv[0];
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
    check({tag, ".accept_wait"}, 64'(guard), 64'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    check({tag, ".latency"}, 64'(lat), (rd && !exp_err) ? 64'(RD_LAT) : 64'd1);
    check({tag, ".err"}, 64'(err), 64'(exp_err));
    check({tag, ".rd_data"}, rd_data, exp_rd);
    check({tag, ".br_taken"}, 64'(br_taken), 64'(exp_br));
    check({tag, ".new_pc"}, new_pc, npc);
    check({tag, ".dm_address"}, dm_address, addr);
    check({tag, ".mem_to_reg_out"}, 64'(mem_to_reg_out), 64'(m2r));
    @(negedge clk);
    check({tag, ".pulse_end"}, 64'(out_valid), 64'd0);
    check({tag, ".ready_back"}, 64'(in_ready), 64'd1);
  endtask

  task automatic mem_op(input string tag, input logic rd, input logic wr, input logic [3:0] sz,
                        input logic [63:0] addr, input logic [63:0] wdata);
    exec(tag, rd, wr, sz, addr, wdata, 1'b0, 2'd0, 3'($urandom_range(0, 7)), {$urandom, $urandom});
  endtask

  initial begin
    int lo, pulses, guard;
    tests = 0; fails = 0;
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    reset = 1'b1; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0;
    xfer_size = 4'd0; alu_result = '0; write_data = '0; new_pc_ex = '0; branch = 1'b0;
    br_mode = 2'd0; zero = 1'b0; negative = 1'b0; overflow = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("reset.in_ready", 64'(in_ready), 64'd1);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.rd_data", rd_data, 64'd0);
    check("reset.err", 64'(err), 64'd0);
    check("reset.br_taken", 64'(br_taken), 64'd0);
    check("reset.new_pc", new_pc, 64'd0);
    check("reset.dm_address", dm_address, 64'd0);
    check("reset.mem_to_reg_out", 64'(mem_to_reg_out), 64'd0);

    mem_op("st8", 1'b0, 1'b1, 4'd8, 64'd8, 64'h0123456789ABCDEF);
    mem_op("ld8", 1'b1, 1'b0, 4'd8, 64'd8, 64'd0);
    check("ld8.const", rd_data, 64'h0123456789ABCDEF);

    mem_op("st4", 1'b0, 1'b1, 4'd4, 64'd16, 64'h11223344AABBCCDD);
    mem_op("ld1", 1'b1, 1'b0, 4'd1, 64'd16, 64'd0);
    check("ld1.const", rd_data, 64'hAA);
    mem_op("ld2", 1'b1, 1'b0, 4'd2, 64'd18, 64'd0);
    check("ld2.const", rd_data, 64'hCCDD);

    exec("cbz_z1", 1'b0, 1'b0, 4'd0, 64'd0, 64'd0, 1'b0, 2'b01, 3'b100, 64'd64);
    check("cbz_z1.const", 64'(br_taken), 64'd1);
    exec("cbnz_z1", 1'b0, 1'b0, 4'd0, 64'd0, 64'd0, 1'b0, 2'b10, 3'b100, 64'd72);
    exec("blt_n1v0", 1'b0, 1'b0, 4'd0, 64'd0, 64'd0, 1'b0, 2'b11, 3'b010, 64'd80);
    exec("b_uncond", 1'b0, 1'b0, 4'd0, 64'd0, 64'd0, 1'b1, 2'b00, 3'b000, 64'd88);

    mem_op("st_oob", 1'b0, 1'b1, 4'd8, 64'd124, 64'hFFFFFFFFFFFFFFFF);
    check("st_oob.const", 64'(err), 64'd1);
    mem_op("ld_120", 1'b1, 1'b0, 4'd8, 64'd120, 64'd0);
    check("ld_120.const", rd_data, 64'd0);
    mem_op("sz3", 1'b1, 1'b0, 4'd3, 64'd0, 64'd0);
    mem_op("both_en", 1'b1, 1'b1, 4'd4, 64'd0, 64'h5555);
    mem_op("big_addr", 1'b1, 1'b0, 4'd1, 64'hFFFFFFFFFFFFFFFF, 64'd0);

    mem_op("al_st", 1'b0, 1'b1, 4'd8, 64'd0, 64'h0011223344556677);
    mem_op("al_ld4", 1'b1, 1'b0, 4'd4, 64'd2, 64'd0);

    // Back-pressure: in_valid stays high through the whole load.
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; xfer_size = 4'd8; alu_result = 64'd8; in_valid = 1'b1;
    @(posedge clk);
    lo = 0; pulses = 0; guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin
      lo++;
      if (out_valid) pulses++;
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    repeat (4) begin @(negedge clk); if (out_valid) pulses++; end
    check("hold.ready_low", 64'(lo), 64'd2);
    check("hold.pulses", 64'(pulses), 64'd1);

    for (int t = 0; t < 60; t++) begin
      logic [2:0]  kind;
      logic [63:0] a;
      kind = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(100, 135)) : 64'($urandom_range(0, 40));
      exec($sformatf("rnd%0d", t), kind inside {3'd3, 3'd4, 3'd5, 3'd7}, kind inside {3'd0, 3'd1, 3'd2, 3'd7},
           size_tab[$urandom_range(0, 5)], a, {$urandom, $urandom}, 1'($urandom_range(0, 3) == 0),
           2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), {$urandom, $urandom});
    end

    // Reset during LOAD_WAIT aborts the response and clears memory.
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; xfer_size = 4'd8; alu_result = 64'd8; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    pulses = 0;
    repeat (4) begin @(negedge clk); if (out_valid) pulses++; end
    check("rst_lw.pulses", 64'(pulses), 64'd0);
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    mem_read = 1'b0; mem_write = 1'b1; alu_result = 64'd32; write_data = 64'hDEADBEEFCAFEF00D;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.rd_data", rd_data, 64'd0);
    check("rst.in_ready", 64'(in_ready), 64'd1);
    mem_op("rst_ld8", 1'b1, 1'b0, 4'd8, 64'd8, 64'd0);
    check("rst_ld8.const", rd_data, 64'd0);
    mem_op("rst_ld32", 1'b1, 1'b0, 4'd8, 64'd32, 64'd0);
    check("rst_ld32.const", rd_data, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_stage_unit.md
# dmem_stage_unit

Parametrised, multi-cycle memory-access stage for the pipelined CPU, placed between the EX/MEM and MEM/WB boundaries. It accepts one operation per handshake from EX, performs a sized big-endian load or store into an internal byte-addressed data memory with configurable read latency, and resolves the branch decision (B, CBZ, CBNZ, B.LT). It returns registered results to WB and back-pressures EX while an access is in flight.

## Interface
Parameters:
- DATA_W, 64, datapath width in bits; must be a multiple of 8, and at most 64.
- DEPTH, 128, memory size in bytes; must be a power of 2.
- RD_LAT, 2, load latency in cycles from accept to out_valid; must be at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  EX presents an operation.
- in_ready  out  1  unit can accept; high only in IDLE.
- mem_read, mem_write  in  1 each  load and store enables; both high at once is an error.
- mem_to_reg  in  1  passed through to WB.
- xfer_size  in  4  access size in bytes; legal values are 1, 2, 4 and 8, and must not exceed DATA_W/8.
- alu_result  in  DATA_W  byte address.
- write_data  in  DATA_W  store data; the low xfer_size bytes are written.
- new_pc_ex  in  DATA_W  branch target.
- branch  in  1  unconditional branch.
- br_mode  in  2  branch condition: 00 none, 01 CBZ, 10 CBNZ, 11 B.LT.
- zero, negative, overflow  in  1 each  ALU flags.
- out_valid  out  1  one-cycle pulse carrying the registered results below.
- rd_data  out  DATA_W  load result, zero-extended; 0 for non-loads.
- mem_to_reg_out  out  1  registered copy of mem_to_reg.
- br_taken  out  1  registered branch decision.
- new_pc  out  DATA_W  registered copy of new_pc_ex.
- dm_address  out  DATA_W  registered copy of alu_result.
- err  out  1  registered; marks an illegal size, an out-of-range access, both enables high, or (with the macro) a misaligned access.

## Operation
- FSM states: IDLE, LOAD_WAIT, RESP.
- IDLE:
  - in_ready = 1.
  - Accept on in_valid & in_ready, and latch all inputs.
  - Legal store: write memory on the accept edge, then go to RESP.
  - Legal load: load the latency counter with RD_LAT-1 and go to LOAD_WAIT, or go straight to RESP when RD_LAT = 1.
  - Non-memory operation or error: go to RESP with no memory side effects.
- LOAD_WAIT: decrement the counter each cycle; at 0, capture the read data and go to RESP.
- RESP: drive out_valid = 1 for exactly one cycle, then return to IDLE.
- Branch decision: br_taken = branch | (br_mode==01 & zero) | (br_mode==10 & ~zero) | (br_mode==11 & (negative ^ overflow)), evaluated on the flags latched at accept.
- Byte order is big-endian:
  - The byte at the address is the most significant byte of the sized quantity.
  - Load data is right-justified in rd_data; upper bits are 0.
- Range check: address + xfer_size > DEPTH gives err = 1; the access is suppressed and rd_data = 0.
- Errors never write memory and never block the handshake.
- Read-after-write: a load accepted after a store completes returns the stored bytes.

## Timing
- Reset values: state IDLE, in_ready 1 on the cycle after reset, and out_valid, rd_data, mem_to_reg_out, br_taken, new_pc, dm_address, err all 0. All memory bytes are cleared to 0.
- Reset takes priority over any pending operation:
  - It aborts LOAD_WAIT and RESP.
  - A store that is in its accept cycle while reset is asserted is not written.
- Latency from accept to out_valid:
  - Store, non-memory operation or error: 1 cycle.
  - Load: RD_LAT cycles.
- Throughput:
  - Minimum of 2 cycles per operation; in_ready is low in LOAD_WAIT and RESP.
  - in_valid asserted while in_ready = 0 is ignored. EX must hold its inputs until it is accepted.
- Outputs change only on the rising edge. in_ready is decoded from state.

## Configuration
- DMEM_ALIGN_CHECK_EN defined: an address that is not a multiple of xfer_size sets err and suppresses the access.
- DMEM_ALIGN_CHECK_EN undefined: misaligned accesses proceed byte-wise at the exact address; only size and range errors set err.

## Structure
- Shared package dmem_pkg holds:
  - the state enum;
  - the br_mode encodings (BR_NONE, BR_CBZ, BR_CBNZ, BR_BLT);
  - the legal xfer_size constants.
- One sub-module, dmem_byte_array: a DEPTH-byte synchronous-write, combinational-read array with a big-endian sized read/write port and a synchronous clear on reset.
- The FSM, latency counter, checks and branch logic live in dmem_stage_unit.

## Test plan
- Reset, then store 64'h0123456789ABCDEF at address 8 with size 8, then load 8 bytes at address 8:
  - in_ready is 1 after reset.
  - The store's out_valid arrives 1 cycle after accept.
  - The load returns 64'h0123456789ABCDEF, with out_valid RD_LAT = 2 cycles after accept.
- Sized accesses at address 16:
  - Store write_data 64'h...AABBCCDD with size 4.
  - Load size 1 at address 16 → rd_data = 64'hAA.
  - Load size 2 at address 18 → rd_data = 64'hCCDD.
- Branch modes:
  - br_mode = 01, zero = 1 → br_taken = 1, and new_pc equals new_pc_ex (64'd64).
  - br_mode = 10, zero = 1 → br_taken = 0.
  - br_mode = 11, negative = 1, overflow = 0 → br_taken = 1.
- Errors:
  - Store at address 124 with size 8 (DEPTH = 128) → err = 1; a following load of address 120 returns 0.
  - xfer_size = 3 → err = 1.
- Back-pressure and reset:
  - Hold in_valid high across a load: exactly one response, and in_ready is low for 2 cycles.
  - Assert reset in LOAD_WAIT → out_valid never pulses, and memory reads back 0.
- Alignment, with DMEM_ALIGN_CHECK_EN defined: a size-4 load at address 2 → err = 1. Without the macro, the same load returns the bytes at addresses 2..5.
